// File: rtl/alarm_ring_sequencer_if.sv
// Signal bundle between the alarm ring sequencer and its time source, buttons and alarm pin.
// The master side drives time, load and button inputs; the slave side is the sequencer.
interface alarm_ring_sequencer_if;
    logic       sec_tick;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       set_load;
    logic       arm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic       alarm_out;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_cnt;
    logic       set_err;
    logic [1:0] state_dbg;

    modport master (
        output sec_tick, cur_hours, cur_minutes, set_hours, set_minutes, set_load,
        output arm_en, snooze_btn, stop_btn,
        input  alarm_out, ringing, snoozing, snooze_cnt, set_err, state_dbg
    );

    modport slave (
        input  sec_tick, cur_hours, cur_minutes, set_hours, set_minutes, set_load,
        input  arm_en, snooze_btn, stop_btn,
        output alarm_out, ringing, snoozing, snooze_cnt, set_err, state_dbg
    );
endinterface

// File: rtl/alarm_ring_sequencer.sv
// Alarm ring/snooze/stop sequencer: stores the alarm time, fires on the match edge and runs the ring/snooze loop.
// Optional macro ALARM_BEEP_EN turns the steady ring into a 1 s on / 1 s off beep.
module alarm_ring_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input logic                   clk,
    input logic                   rst,
    alarm_ring_sequencer_if.slave bus
);
    localparam int SNZ_TICKS = SNOOZE_MINS * 60;
    localparam int RT_W      = $clog2(RING_SECS + 1);
    localparam int ST_W      = $clog2(SNZ_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RT_W-1:0]   ring_timer_q, ring_timer_d;
    logic [ST_W-1:0]   snz_timer_q, snz_timer_d;
    logic [2:0]        snooze_cnt_q, snooze_cnt_d;
    logic [4:0]        alarm_h_q, alarm_h_d;
    logic [5:0]        alarm_m_q, alarm_m_d;
    logic              match_q, match_d;
    logic              set_err_q, set_err_d;
    logic              alarm_out_q, alarm_out_d;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;

    logic match, trigger, load_ok, can_snooze, ring_done;

    always_comb begin
        match      = (bus.cur_hours == alarm_h_q) && (bus.cur_minutes == alarm_m_q);
        trigger    = match && !match_q && bus.arm_en && (state_q == S_IDLE);
        load_ok    = (bus.set_hours < 5'd24) && (bus.set_minutes < 6'd60);
        can_snooze = snooze_cnt_q < 3'(MAX_SNOOZE);
        ring_done  = bus.sec_tick && (ring_timer_q == RT_W'(RING_SECS - 1));

        state_d      = state_q;
        ring_timer_d = ring_timer_q;
        snz_timer_d  = snz_timer_q;
        snooze_cnt_d = snooze_cnt_q;
        match_d      = match;
        set_err_d    = bus.set_load && !load_ok;
        alarm_h_d    = alarm_h_q;
        alarm_m_d    = alarm_m_q;

        // Loads are independent of the sequencer: they never touch state or timers.
        if (bus.set_load && load_ok) begin
            alarm_h_d = bus.set_hours;
            alarm_m_d = bus.set_minutes;
        end

        if (!bus.arm_en) begin
            state_d      = S_IDLE;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_d      = S_RINGING;
                        ring_timer_d = '0;
                        snooze_cnt_d = '0;
                    end
                end
                S_RINGING: begin
                    if (bus.stop_btn) begin
                        state_d      = S_IDLE;
                        snooze_cnt_d = '0;
                    end else if (bus.snooze_btn && can_snooze) begin
                        state_d      = S_SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                        snz_timer_d  = ST_W'(SNZ_TICKS);
                    end else if (bus.sec_tick) begin
                        ring_timer_d = ring_timer_q + 1'b1;
                        // Window expired: auto-snooze while snoozes remain, otherwise give up
                        // and keep snooze_cnt visible until the next trigger.
                        if (ring_done) begin
                            if (can_snooze) begin
                                state_d      = S_SNOOZE;
                                snooze_cnt_d = snooze_cnt_q + 3'd1;
                                snz_timer_d  = ST_W'(SNZ_TICKS);
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_SNOOZE: begin
                    if (bus.stop_btn) begin
                        state_d      = S_IDLE;
                        snooze_cnt_d = '0;
                    end else if (bus.sec_tick) begin
                        snz_timer_d = snz_timer_q - 1'b1;
                        if (snz_timer_q == ST_W'(1)) begin
                            state_d      = S_RINGING;
                            ring_timer_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        ringing_d  = (state_d == S_RINGING);
        snoozing_d = (state_d == S_SNOOZE);
`ifdef ALARM_BEEP_EN
        if (state_d != S_RINGING) begin
            alarm_out_d = 1'b0;
        end else if (state_q != S_RINGING) begin
            alarm_out_d = 1'b1;
        end else if (bus.sec_tick) begin
            alarm_out_d = !alarm_out_q;
        end else begin
            alarm_out_d = alarm_out_q;
        end
`else
        alarm_out_d = (state_d == S_RINGING);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ring_timer_q <= '0;
            snz_timer_q  <= '0;
            snooze_cnt_q <= '0;
            alarm_h_q    <= '0;
            alarm_m_q    <= '0;
            match_q      <= 1'b0;
            set_err_q    <= 1'b0;
            alarm_out_q  <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_timer_q <= ring_timer_d;
            snz_timer_q  <= snz_timer_d;
            snooze_cnt_q <= snooze_cnt_d;
            alarm_h_q    <= alarm_h_d;
            alarm_m_q    <= alarm_m_d;
            match_q      <= match_d;
            set_err_q    <= set_err_d;
            alarm_out_q  <= alarm_out_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign bus.alarm_out  = alarm_out_q;
    assign bus.ringing    = ringing_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.snooze_cnt = snooze_cnt_q;
    assign bus.set_err    = set_err_q;
    assign bus.state_dbg  = state_q;
endmodule
